// File: rtl/modmul_pkg.sv
// Shared types for the sequential modular multiplier.
package modmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/modmul_seq_addmod.sv
// Modular adder: (x + y) mod m, valid for x, y < m.
module modmul_seq_addmod #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] m,
  output logic [DATA_WIDTH-1:0] sum_c
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  logic [SUM_W-1:0] raw;
  logic [SUM_W-1:0] red;

  // One conditional subtraction suffices because x + y < 2m.
  always_comb begin
    raw   = SUM_W'(x) + SUM_W'(y);
    red   = raw - SUM_W'(m);
    sum_c = raw[DATA_WIDTH-1:0];
    if (raw >= SUM_W'(m)) begin
      sum_c = red[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/modmul_seq.sv
// Sequential (a*b) mod m using MSB-first interleaved double-and-add.
module modmul_seq
  import modmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] m,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] acc, acc_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [DATA_WIDTH-1:0] a_reg, a_n;
  logic [DATA_WIDTH-1:0] b_reg, b_n;
  logic [DATA_WIDTH-1:0] m_reg, m_n;
  logic [DATA_WIDTH-1:0] result_n;
  logic                  done_n;
  logic                  ready_n;
  logic [DATA_WIDTH-1:0] add_y_c;
  logic [DATA_WIDTH-1:0] add_sum_c;

  // Second adder operand: acc while doubling, the latched multiplicand while adding.
  assign add_y_c = (state == ADD) ? a_reg : acc;

  modmul_seq_addmod #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_addmod (
    .x     (acc),
    .y     (add_y_c),
    .m     (m_reg),
    .sum_c (add_sum_c)
  );

  // Next-state and datapath update; result and done are loaded on entry to DONE.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    idx_n    = idx;
    a_n      = a_reg;
    b_n      = b_reg;
    m_n      = m_reg;
    result_n = result;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          m_n     = m;
          acc_n   = '0;
          idx_n   = IDX_W'(DATA_WIDTH - 1);
          state_n = DBL;
        end
      end
      DBL: begin
        acc_n   = add_sum_c;
        state_n = ADD;
      end
      ADD: begin
        if (b_reg[idx]) begin
          acc_n = add_sum_c;
        end
        if (idx == '0) begin
          state_n  = DONE;
          done_n   = 1'b1;
          result_n = acc_n;
        end else begin
          idx_n   = idx - IDX_W'(1);
          state_n = DBL;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    ready_n = (state_n == IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      result <= '0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      idx    <= idx_n;
      a_reg  <= a_n;
      b_reg  <= b_n;
      m_reg  <= m_n;
      result <= result_n;
      done   <= done_n;
      ready  <= ready_n;
    end
  end

endmodule

// File: doc/modmul_seq.md
MODMUL_SEQ -- requirements
Module: modmul_seq

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the operand, modulus and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request a new multiplication; it is sampled only while ready=1.
REQ-005 The module SHALL have port a, input, DATA_WIDTH bits: multiplicand; contract requires a < m.
REQ-006 The module SHALL have port b, input, DATA_WIDTH bits: multiplier; any value is allowed.
REQ-007 The module SHALL have port m, input, DATA_WIDTH bits: modulus; contract requires m >= 2.
REQ-008 The module SHALL have port ready, output, 1 bit: idle and able to accept start.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The module SHALL have port result, output, DATA_WIDTH bits: (a*b) mod m for the last accepted request.

Function
REQ-011 The block SHALL compute (a*b) mod m by MSB-first interleaved double-and-add, using exactly one shared modular-adder datapath that computes (x+y) mod m for x,y < m.
REQ-012 The FSM SHALL have exactly the states IDLE, DBL, ADD and DONE.
REQ-013 In IDLE with start=1 the block SHALL latch a, b and m into internal registers, clear the accumulator acc, set bit index idx=DATA_WIDTH-1 and go to DBL.
REQ-014 In DBL the block SHALL set acc <= (acc+acc) mod m and go to ADD.
REQ-015 In ADD the block SHALL set acc <= (acc+a_reg) mod m if b_reg[idx]=1 and hold acc otherwise.
REQ-016 From ADD the block SHALL go to DONE if idx=0; otherwise it SHALL decrement idx and go to DBL.
REQ-017 In DONE the block SHALL assert done=1 for exactly one cycle, load result <= acc, and then go to IDLE.
REQ-018 Latency SHALL be fixed and independent of the operand values: when start is accepted at edge 0, done SHALL be high during cycle 2*DATA_WIDTH+1 (17 for DATA_WIDTH=8).
REQ-019 The adder x/y multiplexing SHALL follow the state:
  - DBL: x=acc, y=acc.
  - ADD: x=acc, y=a_reg.
  - All modulus inputs: m_reg.
REQ-020 ready SHALL be 1 only in IDLE.
REQ-021 start in DBL, ADD or DONE SHALL be ignored, with no effect on the operation in flight or on the latched operands.
REQ-022 Input changes on a, b or m after acceptance SHALL NOT affect the operation in flight.
REQ-023 result SHALL hold its value from DONE until the next DONE.
REQ-024 For out-of-contract inputs (a >= m, m < 2), result is unspecified, but the FSM SHALL still complete with the REQ-018 latency and return to IDLE.
REQ-025 The invariant acc < m SHALL hold after every DBL and ADD update whenever inputs are in contract.

Reset
REQ-026 When rst_n=0 at a rising edge, the state SHALL become IDLE, acc, idx, the operand registers and result SHALL become 0, and done SHALL become 0.
REQ-027 After reset, ready SHALL be 1 in the first cycle following the reset edge.
REQ-028 A reset asserted mid-operation (DBL or ADD) SHALL abort the operation, with no done pulse for the aborted request.
REQ-029 The block SHALL accept a new start in the first cycle after rst_n returns to 1.

Structure
REQ-030 A shared package modmul_pkg SHALL hold the FSM state enum (IDLE, DBL, ADD, DONE).
REQ-031 The package SHALL NOT hold DATA_WIDTH, which SHALL remain a module parameter.
REQ-032 The block SHALL contain exactly one instance of the team's existing modular adder module as its only sub-module, parameterised with the same DATA_WIDTH.
REQ-033 The block SHALL contain no other arithmetic beyond the idx decrement and compare.

Verification (DATA_WIDTH=8)
REQ-034 Basic case: a=3, b=5, m=7, start pulse -> done on cycle 17 with result=1, and ready=0 during cycles 1..17.
REQ-035 Zero/max cases:
  - a=6, b=0, m=7 -> result=0.
  - a=250, b=250, m=251 -> result=1.
  - a=0, b=255, m=13 -> result=0.
REQ-036 Busy-start case: start a=3, b=5, m=7, then hold start=1 with a=2, b=2, m=7 throughout cycles 1..17 -> exactly one done, result=1; the second request is accepted only after returning to IDLE (cycle 18), giving done at cycle 35 with result=4.
REQ-037 Reset mid-operation: pull rst_n=0 for one edge at cycle 6 of an operation -> no done, result=0, ready=1 the next cycle, and a subsequent a=4, b=4, m=5 -> result=1.
REQ-038 Random compare: 1000 random in-contract triples checked against a reference (a*b)%m -> all match with fixed latency 17, and acc<m is asserted every cycle.
